// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared size encodings, FSM states and latency bounds for the data memory.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: byte-lane enables, store replication, load extraction/extension and alignment check.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sext,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b        = rword[{lane, 3'b000} +: 8];
    h        = lane[1] ? rword[31:16] : rword[15:0];
    misalign = size == SZ_ILL || (size == SZ_HALF && lane[0]) || (size == SZ_WORD && lane != 2'b00);
    be       = size == SZ_BYTE ? 4'b0001 << lane :
               size == SZ_HALF ? (lane[1] ? 4'b1100 : 4'b0011) :
               size == SZ_WORD ? 4'b1111 : 4'b0000;
    wword    = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata    = size == SZ_BYTE ? {{24{sext & b[7]}}, b} :
               size == SZ_HALF ? {{16{sext & h[15]}}, h} :
               size == SZ_WORD ? rword : 32'd0;
  end
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory with valid/ready requests and fixed response latency.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = LAT > 1 ? 2'(LAT - 2) : 2'd0;
  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_lat_chk
    $error("data_mem_ctrl: LAT out of range");
  end
  logic [3:0][7:0] mem [DEPTH];
  state_t          state;
  logic [1:0]      cnt;
  logic [AW-1:0]   idx;
  logic [3:0]      be;
  logic [31:0]     wword, ldata, pend_rdata;
  logic            misalign, oor, err, accept, pend_err;
  assign idx       = req_addr[AW+1:2];
  assign oor       = |(req_addr >> (AW + 2));
  assign err       = misalign | oor;
  assign req_ready = rst || state == IDLE;
  assign accept    = req_valid && req_ready && !rst;
  mem_lane_align u_align (
    .size     (req_size),
    .lane     (req_addr[1:0]),
    .sext     (req_signed),
    .wdata    (req_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wword    (wword),
    .rdata    (ldata),
    .misalign (misalign)
  );
  // Memory is deliberately outside the reset domain: accepted stores survive rst.
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (accept && req_we && !err && be[i]) mem[idx][i] <= wword[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 1'b0;
      pend_rdata <= 32'd0;
      pend_err   <= 1'b0;
    end else begin
      rsp_valid <= state == RESP;
      if (state == RESP) begin
        rsp_rdata <= pend_rdata;
        rsp_err   <= pend_err;
      end
      if (accept) begin
        pend_rdata <= err || req_we ? 32'd0 : ldata;
        pend_err   <= err;
        cnt        <= CNT_INIT;
      end else if (state == WAIT && cnt != 2'd0) cnt <= cnt - 2'd1;
      state <= accept ? (LAT > 1 ? WAIT : RESP) :
               state == WAIT ? (cnt == 2'd0 ? RESP : WAIT) :
               state == RESP ? IDLE : state;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: LAT=1 and LAT=3 instances checked every cycle against a byte-array model.
module tb_data_mem_ctrl;
  import mips_mem_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic        rv[2], we[2], sg[2], rdy[2], vld[2], er[2];
  logic [1:0]  sz[2];
  logic [31:0] ad[2], wd[2], rd[2];
  always #5 clk = ~clk;
  data_mem_ctrl #(.DEPTH(1024), .ADDR_W(32), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rdy[0]), .req_we(we[0]),
    .req_size(sz[0]), .req_signed(sg[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
    .rsp_valid(vld[0]), .rsp_rdata(rd[0]), .rsp_err(er[0])
  );
  data_mem_ctrl #(.DEPTH(1024), .ADDR_W(32), .LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rdy[1]), .req_we(we[1]),
    .req_size(sz[1]), .req_signed(sg[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
    .rsp_valid(vld[1]), .rsp_rdata(rd[1]), .rsp_err(er[1])
  );
  // Reference model: byte-wide little-endian memory plus one outstanding response per instance.
  int          cyc;
  logic [7:0]  mm [2][4096];
  bit          pend[2], acc_now[2], vexp[2], exp_er[2], last_er[2];
  int          due[2], acc_edge[2], acc_cnt[2];
  logic [31:0] exp_rd[2], last_rd[2];
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      bit          r, e;
      int          nb;
      logic [31:0] v;
      r = !pend[i];
      acc_now[i] = 0;
      vexp[i] = 0;
      if (rst) begin
        pend[i] = 0;
        last_rd[i] = 32'd0;
        last_er[i] = 0;
      end else begin
        if (pend[i] && cyc == due[i]) begin
          vexp[i] = 1;
          last_rd[i] = exp_rd[i];
          last_er[i] = exp_er[i];
          pend[i] = 0;
        end
        if (rv[i] && r) begin
          e = sz[i] == 2'd3 || (sz[i] == 2'd1 && ad[i] % 2 != 0) ||
              (sz[i] == 2'd2 && ad[i] % 4 != 0) || ad[i] >= 32'h1000;
          nb = 1 << sz[i];
          v = 32'd0;
          if (!e)
            for (int k = 0; k < nb; k++)
              if (we[i]) mm[i][ad[i] + k] = wd[i][8*k +: 8];
              else v = v + (32'(mm[i][ad[i] + k]) << (8 * k));
          if (!e && !we[i] && sg[i] && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
          exp_rd[i] = e || we[i] ? 32'd0 : v;
          exp_er[i] = e;
          pend[i] = 1;
          due[i] = cyc + (i == 0 ? 1 : 3);
          acc_edge[i] = cyc;
          acc_cnt[i] = acc_cnt[i] + 1;
          acc_now[i] = 1;
        end
      end
    end
  end
  // Compare process: every output of both instances, every cycle after the first reset edge.
  int          checks, errors;
  bit          lit_on[2], lit_er[2], lit_gap[2], seen[2];
  logic [31:0] lit_rd[2];
  int          lit_lat[2], low_cnt[2], prev_acc[2];
  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cyc %0d got %h want %h", n, i, cyc, act, exp);
    end
  endtask
  always @(negedge clk) if (cyc > 0) for (int i = 0; i < 2; i++) begin
    chk("req_ready", i, 32'(rdy[i]), 32'(rst || !pend[i]));
    chk("rsp_valid", i, 32'(vld[i]), 32'(vexp[i]));
    chk("rsp_rdata", i, rd[i], last_rd[i]);
    chk("rsp_err", i, 32'(er[i]), 32'(last_er[i]));
    if (vexp[i] && lit_on[i]) begin
      chk("lit_rdata", i, rd[i], lit_rd[i]);
      chk("lit_err", i, 32'(er[i]), 32'(lit_er[i]));
      chk("lit_latency", i, 32'(cyc - acc_edge[i] + 1), 32'(lit_lat[i]));
    end
    if (acc_now[i]) begin
      if (lit_gap[i] && seen[i]) begin
        chk("accept_gap", i, 32'(cyc - prev_acc[i]), 32'd4);
        chk("ready_low", i, 32'(low_cnt[i]), 32'd3);
      end
      seen[i] = lit_gap[i];
      prev_acc[i] = cyc;
      low_cnt[i] = rdy[i] ? 0 : 1;
    end else if (!rdy[i]) low_cnt[i]++;
  end
  task automatic req(int i, bit w, logic [1:0] s, bit g, logic [31:0] a, logic [31:0] d, bit hold);
    int c0, n;
    we[i] = w; sz[i] = s; sg[i] = g; ad[i] = a; wd[i] = d; rv[i] = 1'b1;
    c0 = acc_cnt[i];
    n = 0;
    while (acc_cnt[i] == c0) begin
      @(negedge clk);
      n++;
      if (n > 50) begin
        $display("FAIL handshake[%0d] no accept within %0d cycles", i, n);
        $fatal(1, "handshake timeout");
      end
    end
    if (!hold) rv[i] = 1'b0;
  endtask
  task automatic lit_req(int i, bit w, logic [1:0] s, bit g, logic [31:0] a, logic [31:0] d,
                         logic [31:0] xrd, bit xer, int xlat);
    lit_rd[i] = xrd; lit_er[i] = xer; lit_lat[i] = xlat; lit_on[i] = 1;
    req(i, w, s, g, a, d, 0);
    for (int n = 0; n < 10 && pend[i]; n++) @(negedge clk);
    @(negedge clk);
    lit_on[i] = 0;
  endtask
  task automatic rand_ops(int i, int cnt);
    logic [31:0] a;
    logic [1:0]  s;
    for (int n = 0; n < cnt; n++) begin
      s = 2'($urandom_range(0, 3));
      a = $urandom_range(0, 15) == 0 ? 32'h1000 + $urandom_range(0, 255) : $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0 && s != 2'd3) a = a & ~((32'd1 << s) - 1);
      req(i, 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
      if (!rv[i]) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rv[i] = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; we[i] = 0; sg[i] = 0; sz[i] = 2'd0; ad[i] = 32'd0; wd[i] = 32'd0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    lit_req(0, 1, SZ_WORD, 0, 32'h0,  32'hCAFEF00D, 32'h0, 0, 2);
    lit_req(0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2);
    lit_req(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2);
    lit_req(0, 1, SZ_BYTE, 0, 32'h11, 32'h0000007F, 32'h0, 0, 2);
    lit_req(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 2);
    lit_req(0, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2);
    lit_req(0, 0, SZ_BYTE, 0, 32'h13, 32'h0, 32'h000000DE, 0, 2);
    lit_req(0, 0, SZ_HALF, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 2);
    lit_req(0, 0, SZ_HALF, 0, 32'h10, 32'h0, 32'h00007FEF, 0, 2);
    lit_req(0, 0, SZ_WORD, 0, 32'h12, 32'h0, 32'h0, 1, 2);
    lit_req(0, 1, SZ_HALF, 0, 32'h11, 32'h0000BEEF, 32'h0, 1, 2);
    lit_req(0, 0, SZ_ILL,  0, 32'h10, 32'h0, 32'h0, 1, 2);
    lit_req(0, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEAD7FEF, 0, 2);
    lit_req(0, 1, SZ_WORD, 0, 32'h1000, 32'h55555555, 32'h0, 1, 2);
    lit_req(0, 0, SZ_WORD, 0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 2);
    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 64; w++) req(i, 1, SZ_WORD, 0, 32'(w * 4), $urandom, 1);
      rv[i] = 1'b0;
      repeat (6) @(negedge clk);
    end
    rand_ops(0, 300);
    rand_ops(1, 300);
    lit_req(1, 1, SZ_WORD, 0, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 4);
    lit_gap[1] = 1;
    for (int n = 0; n < 4; n++) req(1, 0, SZ_WORD, 0, 32'h40, 32'h0, n < 3);
    repeat (6) @(negedge clk);
    lit_gap[1] = 0;
    req(1, 1, SZ_WORD, 0, 32'h20, 32'h12345678, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    lit_req(1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h12345678, 0, 4);
    lit_req(0, 0, SZ_WORD, 0, 32'h0, 32'h0, exp_word0(), 0, 2);
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  function automatic logic [31:0] exp_word0();
    return {mm[0][3], mm[0][2], mm[0][1], mm[0][0]};
  endfunction
endmodule
